// File: rtl/multu_hilo_unit_pkg.sv
// rtl/multu_hilo_unit_pkg.sv - funct select constants and FSM state encoding for the MULTU unit
package multu_hilo_unit_pkg;

    localparam int MULTU_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_OUT   = 6'b111111;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multu_hilo_unit_datapath.sv
// rtl/multu_hilo_unit_datapath.sv - shift-add product register with captured multiplicand
module multu_hilo_unit_datapath
    import multu_hilo_unit_pkg::*;
#(
    parameter int WIDTH = MULTU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     upper_sum;

    // The W+1-bit sum keeps the carry, which lands in bit 2W-1 after the shift.
    always_comb begin
        upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d  = prod_q;
        mcand_d = mcand_q;
        if (load_i) begin
            prod_d  = {{WIDTH{1'b0}}, mplier_i};
            mcand_d = mcand_i;
        end else if (step_i) begin
            prod_d = {upper_sum, prod_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/multu_hilo_unit.sv
// rtl/multu_hilo_unit.sv - sequential 32x32 unsigned multiplier with HI/LO registers and readout mux
module multu_hilo_unit
    import multu_hilo_unit_pkg::*;
#(
    parameter int WIDTH = MULTU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       sel,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               load, step;
    logic [2*WIDTH-1:0] prod;
    logic               is_multu, is_out;

    assign is_multu = (sel == FUNCT_MULTU);
    assign is_out   = (sel == FUNCT_OUT);

    multu_hilo_unit_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (srcA),
        .mplier_i (srcB),
        .prod_o   (prod)
    );

    // armed forces sel to leave MULTU between runs, so a held select fires only once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_multu && armed_q) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    state_d = ST_RUN;
                end else if (!is_multu) begin
                    armed_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!is_multu && !is_out) begin
                    armed_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        dataOut = '0;
        if (sel == FUNCT_MFHI) begin
            dataOut = hi_q;
        end else if (sel == FUNCT_MFLO || sel == FUNCT_OUT) begin
            dataOut = lo_q;
        end
    end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb/tb_multu_hilo_unit.sv - randomized self-checking bench for multu_hilo_unit
module tb_multu_hilo_unit;
    import multu_hilo_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [5:0]  sel;
    logic [31:0] srcA, srcB;
    logic        busy, done;
    logic [31:0] hi, lo, dataOut;

    int n_vec;
    int n_err;
    logic [31:0] exp_hi, exp_lo;

    multu_hilo_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .srcA    (srcA),
        .srcB    (srcB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    // Runs one full multiply; optionally scrambles operands mid-run.
    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble);
        logic [63:0] p;
        int done_at;
        p = {32'd0, a} * {32'd0, b};
        srcA = a;
        srcB = b;
        sel  = FUNCT_MULTU;
        done_at = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            tick();
            if (scramble && i == 5) begin
                srcA = $urandom;
                srcB = $urandom;
            end
            if (done) done_at = i;
        end
        chk({tag, "_latency"}, 64'(done_at), 64'd33);
        tick();
        sel = FUNCT_OUT;
        #1;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        check_regs(tag);
        chk({tag, "_done_drop"}, {63'd0, done}, 64'd0);
        chk({tag, "_out"}, {32'd0, dataOut}, {32'd0, exp_lo});
        sel = FUNCT_MFHI;
        #1;
        chk({tag, "_mfhi"}, {32'd0, dataOut}, {32'd0, exp_hi});
        sel = FUNCT_ADD;
        tick();
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        sel   = FUNCT_ADD;
        srcA  = '0;
        srcB  = '0;
        exp_hi = '0;
        exp_lo = '0;
        tick();
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        check_regs("rst");
        rst_n = 1'b1;
        tick();

        do_mult("basic", 32'd7, 32'd9, 1'b0);
        do_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        sel = FUNCT_MFLO;
        #1;
        chk("max_mflo", {32'd0, dataOut}, 64'h1);
        sel = FUNCT_ADD;
        #1;
        chk("other_sel", {32'd0, dataOut}, 64'd0);
        do_mult("hold", 32'h0001_0000, 32'h0001_0000, 1'b1);
        do_mult("zero_a", 32'd0, $urandom, 1'b0);
        do_mult("zero_b", $urandom, 32'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom;
            do_mult("rand", ra, rb, 1'b1);
        end

        // Abort after 12 cycles of MULTU
        srcA = 32'd5;
        srcB = 32'd6;
        sel  = FUNCT_MULTU;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_busy_pre", {63'd0, busy}, 64'd1);
        sel = FUNCT_ADD;
        pulses = 0;
        tick();
        chk("abort_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        check_regs("abort");

        // Held MULTU fires exactly once
        ra = $urandom;
        rb = $urandom;
        srcA = ra;
        srcB = rb;
        sel  = FUNCT_MULTU;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("hold_pulses", 64'(pulses), 64'd1);
        chk("hold_idle", {63'd0, busy}, 64'd0);
        exp_hi = 32'(({32'd0, ra} * {32'd0, rb}) >> 32);
        exp_lo = ra * rb;
        check_regs("hold_once");
        sel = FUNCT_ADD;
        tick();
        sel = FUNCT_MULTU;
        tick();
        chk("rearm_busy", {63'd0, busy}, 64'd1);
        sel = FUNCT_ADD;
        tick();
        tick();

        // Reset mid-run after a known-nonzero result
        do_mult("pre_rst", 32'd1234, 32'd5678, 1'b0);
        srcA = 32'd7;
        srcB = 32'd9;
        sel  = FUNCT_MULTU;
        for (int i = 0; i < 11; i++) tick();
        rst_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        check_regs("midrst");
        tick();
        rst_n = 1'b1;
        sel = FUNCT_ADD;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
